keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 251 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad. Drives one column at a time and looks at the
// synchronized row lines at the end of each column dwell. A detected key is
// debounced for press and release. Each accepted press gives a one-cycle
// pulse, updates the key code and shifts the code into a short history.
//
// Parameters
//   SCAN_DIV        clock cycles each column is driven while scanning (>= 2)
//   DEBOUNCE_CYCLES consecutive stable cycles to accept a press/release (>= 1)
//   HIST_DEPTH      number of accepted key codes kept in digits (>= 1)
//
// Ports
//   clk        in   1            single clock, rising edge
//   reset_n    in   1            synchronous reset, active low
//   rows       in   4            asynchronous keypad row lines, active high
//   cols       out  4            one-hot column drive, active high
//   key_valid  out  1            one-cycle pulse per accepted press
//   key_code   out  4            code of the most recent accepted key
//   digits     out  4*HIST_DEPTH key history, newest code in [3:0]
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HIST_DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              rows,
  output logic [3:0]              cols,
  output logic                    key_valid,
  output logic [3:0]              key_code,
  output logic [4*HIST_DEPTH-1:0] digits
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIG_W   = 4 * HIST_DEPTH;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Key code for a (row, column index) position of the matrix.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Index of the lowest set row bit (row 0 wins when several keys share a column).
  function automatic logic [1:0] lowest_row(input logic [3:0] r);
    logic [1:0] idx;
    if (r[0]) begin
      idx = 2'd0;
    end else if (r[1]) begin
      idx = 2'd1;
    end else if (r[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Column index of the one-hot column drive.
  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    case (c)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Next column; an illegal drive pattern recovers to column 0.
  function automatic logic [3:0] next_col(input logic [3:0] c);
    logic [3:0] n;
    case (c)
      4'b0001: n = 4'b0010;
      4'b0010: n = 4'b0100;
      4'b0100: n = 4'b1000;
      4'b1000: n = 4'b0001;
      default: n = 4'b0001;
    endcase
    return n;
  endfunction

  // Saturating counter increment; the counter never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  logic [3:0]       rows_meta_r;
  logic [3:0]       rs_r;
  state_t           state_r,     state_s;
  logic [CNT_W-1:0] cnt_r,       cnt_s;
  logic [3:0]       cols_r,      cols_s;
  logic [1:0]       row_idx_r,   row_idx_s;
  logic             key_valid_r, key_valid_s;
  logic [3:0]       key_code_r,  key_code_s;
  logic [DIG_W-1:0] digits_r,    digits_s;
  logic             row_bit_s;
  logic [3:0]       new_code_s;

  // Level of the latched row, and the code of the latched key at the frozen column.
  assign row_bit_s  = rs_r[row_idx_r];
  assign new_code_s = key_map(row_idx_r, col_index(cols_r));

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rows_meta_r <= 4'b0000;
      rs_r        <= 4'b0000;
    end else begin
      rows_meta_r <= rows;
      rs_r        <= rows_meta_r;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= SCAN;
      cnt_r       <= CNT_ZERO;
      cols_r      <= 4'b0001;
      row_idx_r   <= 2'd0;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      digits_r    <= {DIG_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cols_r      <= cols_s;
      row_idx_r   <= row_idx_s;
      key_valid_r <= key_valid_s;
      key_code_r  <= key_code_s;
      digits_r    <= digits_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cols_s      = cols_r;
    row_idx_s   = row_idx_r;
    key_valid_s = 1'b0;
    key_code_s  = key_code_r;
    digits_s    = digits_r;
    case (state_r)
      SCAN: begin
        // Rows are only looked at on the last cycle of a column dwell.
        if (cnt_r >= SCAN_LAST) begin
          cnt_s = CNT_ZERO;
          if (rs_r != 4'b0000) begin
            row_idx_s = lowest_row(rs_r);
            state_s   = PRESS_DB;
          end else begin
            cols_s = next_col(cols_r);
          end
        end else begin
          cnt_s = sat_inc(cnt_r);
        end
      end
      PRESS_DB: begin
        if (row_bit_s) begin
          cnt_s = sat_inc(cnt_r);
          // The counter reaches DEBOUNCE_CYCLES on this cycle: accept.
          if (cnt_r >= DB_LAST) begin
            state_s     = HELD;
            key_valid_s = 1'b1;
            key_code_s  = new_code_s;
            // Keep the low DIG_W bits: shifts history up, oldest nibble drops out.
            digits_s    = DIG_W'({digits_r, new_code_s});
          end else begin
            state_s = PRESS_DB;
          end
        end else begin
          state_s = SCAN;
          cnt_s   = CNT_ZERO;
          cols_s  = next_col(cols_r);
        end
      end
      HELD: begin
        // Other rows are deliberately ignored here; only the latched row matters.
        if (!row_bit_s) begin
          state_s = RELEASE_DB;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = HELD;
        end
      end
      RELEASE_DB: begin
        if (!row_bit_s) begin
          if (cnt_r >= DB_LAST) begin
            state_s = SCAN;
            cnt_s   = CNT_ZERO;
            cols_s  = next_col(cols_r);
          end else begin
            cnt_s = sat_inc(cnt_r);
          end
        end else begin
          state_s = HELD;
          cnt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_s = SCAN;
        cnt_s   = CNT_ZERO;
        cols_s  = 4'b0001;
      end
    endcase
  end

  assign cols      = cols_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign digits    = digits_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner (SCAN_DIV=2, DEBOUNCE_CYCLES=4,
// HIST_DEPTH=2). Keys are applied by driving the row lines during the dwell of
// the column just before the target column, so that the synchronized rows are
// seen at the end of the target column's dwell. A reference model keeps the
// expected key code and the history of accepted codes.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 2;
  localparam int DEB      = 4;
  localparam int HIST     = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] digits;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .HIST_DEPTH(HIST)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rows(rows),
    .cols(cols),
    .key_valid(key_valid),
    .key_code(key_code),
    .digits(digits)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Key legend in row-major order (row*4 + column).
  logic [3:0] code_tbl [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  // Reference model state: newest accepted code in hist[0].
  logic [3:0] hist [HIST];
  logic [3:0] exp_code;

  // Pulse monitor, sampled mid-cycle.
  int         pulse_cnt = 0;
  logic [3:0] pulse_code;
  logic [7:0] pulse_digits;

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_cnt    <= pulse_cnt + 1;
      pulse_code   <= key_code;
      pulse_digits <= digits;
    end
  end

  function automatic logic [7:0] exp_digits();
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < HIST; i++) d[4*i +: 4] = hist[i];
    return d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HIST; i++) hist[i] = 4'h0;
    exp_code = 4'h0;
  endtask

  task automatic model_accept(input logic [3:0] code);
    for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0]  = code;
    exp_code = code;
  endtask

  function automatic int lowest_set(input logic [3:0] m);
    int r;
    r = 0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the given column is driven, at a negedge.
  task automatic wait_col(input int c, output bit ok);
    logic [3:0] want;
    want = 4'(1 << c);
    ok   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cols === want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drive row mask so it is evaluated while column c is driven, then hold.
  task automatic press(input logic [3:0] mask, input int c, input int hold);
    bit ok;
    wait_col((c + 3) % 4, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL press_sync: column %0d never driven (cols=%b)", (c + 3) % 4, cols);
    end
    rows = mask;
    tick(hold);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rows    = 4'b0000;
    model_reset();
    tick(3);
    n_checks++; if (cols !== 4'b0001) begin n_fail++; $display("FAIL reset_cols: got %b want 0001", cols); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h want 0", key_code); end
    n_checks++; if (digits !== 8'h00) begin n_fail++; $display("FAIL reset_digits: got %h want 00", digits); end
    reset_n = 1'b1;
    tick(1);
    n_checks++; if (cols !== 4'b0001) begin n_fail++; $display("FAIL scan_start: got %b want 0001", cols); end
    tick(1);
    n_checks++; if (cols !== 4'b0010) begin n_fail++; $display("FAIL scan_col1: got %b want 0010", cols); end
    tick(2);
    n_checks++; if (cols !== 4'b0100) begin n_fail++; $display("FAIL scan_col2: got %b want 0100", cols); end
  endtask

  task automatic test_single_press();
    int base;
    base = pulse_cnt;
    press(4'b0001, 1, 20);
    model_accept(code_tbl[0*4 + 1]);
    rows = 4'b0000;
    tick(10);
    n_checks++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulse_cnt - base); end
    n_checks++; if (pulse_code !== exp_code) begin n_fail++; $display("FAIL single_pulse_code: got %h want %h", pulse_code, exp_code); end
    n_checks++; if (pulse_digits !== exp_digits()) begin n_fail++; $display("FAIL single_pulse_digits: got %h want %h", pulse_digits, exp_digits()); end
    n_checks++; if (key_code !== exp_code) begin n_fail++; $display("FAIL single_code_held: got %h want %h", key_code, exp_code); end
    n_checks++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL single_digits: got %h want %h", digits, exp_digits()); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = pulse_cnt;
    press(4'b0010, 1, 20);
    model_accept(code_tbl[1*4 + 1]);
    rows = 4'b0000;
    tick(8);
    n_checks++; if (key_code !== exp_code) begin n_fail++; $display("FAIL b2b_first_code: got %h want %h", key_code, exp_code); end
    n_checks++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL b2b_first_digits: got %h want %h", digits, exp_digits()); end
    press(4'b1000, 3, 20);
    model_accept(code_tbl[3*4 + 3]);
    rows = 4'b0000;
    tick(10);
    n_checks++; if (pulse_cnt - base !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - base); end
    n_checks++; if (key_code !== exp_code) begin n_fail++; $display("FAIL b2b_code: got %h want %h", key_code, exp_code); end
    n_checks++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL b2b_digits: got %h want %h", digits, exp_digits()); end
  endtask

  task automatic test_short_press();
    int base;
    bit ok;
    base = pulse_cnt;
    press(4'b0100, 2, 2);
    rows = 4'b0000;
    wait_col(3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL short_resume: got cols=%b want 1000 within bound", cols); end
    tick(10);
    n_checks++; if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL short_pulses: got %0d want 0", pulse_cnt - base); end
    n_checks++; if (key_code !== exp_code) begin n_fail++; $display("FAIL short_code: got %h want %h", key_code, exp_code); end
    n_checks++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL short_digits: got %h want %h", digits, exp_digits()); end
  endtask

  task automatic test_release_bounce();
    int base;
    logic [3:0] want;
    base = pulse_cnt;
    press(4'b0100, 0, 12);
    model_accept(code_tbl[2*4 + 0]);
    // Low 2, high 1, then low: one entry cycle plus DEB counted lows, 2-cycle sync lag.
    for (int i = 0; i <= 10; i++) begin
      rows = (i == 2) ? 4'b0100 : 4'b0000;
      want = (i < 10) ? 4'b0001 : 4'b0010;
      n_checks++;
      if (cols !== want) begin
        n_fail++;
        $display("FAIL bounce_cols[%0d]: got %b want %b", i, cols, want);
      end
      if (i < 10) @(negedge clk);
    end
    tick(4);
    n_checks++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL bounce_pulses: got %0d want 1", pulse_cnt - base); end
    n_checks++; if (pulse_code !== exp_code) begin n_fail++; $display("FAIL bounce_code: got %h want %h", pulse_code, exp_code); end
    n_checks++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL bounce_digits: got %h want %h", digits, exp_digits()); end
  endtask

  task automatic test_two_keys();
    int base;
    base = pulse_cnt;
    press(4'b0101, 2, 12);
    model_accept(code_tbl[0*4 + 2]);
    rows = 4'b0111; tick(3);
    rows = 4'b0101; tick(3);
    rows = 4'b0001; tick(3);
    rows = 4'b1001; tick(3);
    rows = 4'b0000; tick(10);
    n_checks++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL two_keys_pulses: got %0d want 1", pulse_cnt - base); end
    n_checks++; if (key_code !== exp_code) begin n_fail++; $display("FAIL two_keys_code: got %h want %h", key_code, exp_code); end
    n_checks++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL two_keys_digits: got %h want %h", digits, exp_digits()); end
  endtask

  task automatic test_random();
    int base, c, hold, rel, r;
    logic [3:0] mask;
    for (int k = 0; k < 12; k++) begin
      base = pulse_cnt;
      mask = 4'($urandom_range(1, 15));
      c    = $urandom_range(0, 3);
      hold = $urandom_range(10, 24);
      rel  = $urandom_range(8, 14);
      r    = lowest_set(mask);
      press(mask, c, hold);
      rows = 4'b0000;
      tick(rel);
      model_accept(code_tbl[r*4 + c]);
      n_checks++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL rand_pulses[%0d]: got %0d want 1", k, pulse_cnt - base); end
      n_checks++; if (pulse_code !== exp_code) begin n_fail++; $display("FAIL rand_code[%0d]: rows=%b col=%0d got %h want %h", k, mask, c, pulse_code, exp_code); end
      n_checks++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL rand_digits[%0d]: got %h want %h", k, digits, exp_digits()); end
    end
  endtask

  task automatic test_reset_midop();
    int base;
    // Reset while in HELD.
    base = pulse_cnt;
    press(4'b0001, 3, 12);
    reset_n = 1'b0;
    model_reset();
    tick(1);
    n_checks++; if (cols !== 4'b0001) begin n_fail++; $display("FAIL held_reset_cols: got %b want 0001", cols); end
    n_checks++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL held_reset_code: got %h want 0", key_code); end
    n_checks++; if (digits !== 8'h00) begin n_fail++; $display("FAIL held_reset_digits: got %h want 00", digits); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL held_reset_valid: got %b want 0", key_valid); end
    tick(2);
    rows    = 4'b0000;
    reset_n = 1'b1;
    tick(1);
    n_checks++; if (cols !== 4'b0001) begin n_fail++; $display("FAIL held_reset_restart: got %b want 0001", cols); end
    n_checks++; if (pulse_cnt - base !== 1) begin n_fail++; $display("FAIL held_reset_pulses: got %0d want 1", pulse_cnt - base); end
    // Reset while debouncing a press: the press must never be accepted.
    tick(4);
    base = pulse_cnt;
    press(4'b0010, 1, 5);
    reset_n = 1'b0;
    tick(4);
    rows    = 4'b0000;
    reset_n = 1'b1;
    tick(12);
    n_checks++; if (pulse_cnt - base !== 0) begin n_fail++; $display("FAIL pressdb_reset_pulses: got %0d want 0", pulse_cnt - base); end
    n_checks++; if (key_code !== exp_code) begin n_fail++; $display("FAIL pressdb_reset_code: got %h want %h", key_code, exp_code); end
    n_checks++; if (digits !== exp_digits()) begin n_fail++; $display("FAIL pressdb_reset_digits: got %h want %h", digits, exp_digits()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_back_to_back();
    test_short_press();
    test_release_bounce();
    test_two_keys();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
